// File: rtl/regs_param.sv
// Parametrised register file for the picoMIPS datapath. Register %0 reads zero.
// After reset a clear engine zeroes every register in turn; busy is high while it runs.
module regs_param #(
    parameter int N       = 8,
    parameter int NREGS   = 8,
    parameter int A       = $clog2(NREGS),
    parameter int BYPASS  = 1,
    parameter int TAP_REG = NREGS - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         w,
    input  logic [A-1:0] waddr,
    input  logic [N-1:0] wdata,
    input  logic [A-1:0] raddr1,
    input  logic [A-1:0] raddr2,
    output logic [N-1:0] rdata1,
    output logic [N-1:0] rdata2,
    output logic [N-1:0] tap,
    output logic         busy
);

    typedef enum logic {INIT, RUN} state_t;

    state_t       state;
    logic [A-1:0] cnt;
    logic [N-1:0] gpr [1:NREGS-1];
    logic [NREGS-1:1] reg_we;
    logic [N-1:0] reg_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= A'(1);
        end else if (state == INIT) begin
            cnt <= cnt + A'(1);
            if (cnt == A'(NREGS - 1))
                state <= RUN;
        end
    end

    // The clear engine and user writes share one write port; INIT owns it exclusively.
    always_comb begin
        reg_we = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (state == INIT)
                reg_we[i] = (cnt == A'(i));
            else
                reg_we[i] = w && (waddr == A'(i));
        end
    end

    assign reg_d = (state == INIT) ? '0 : wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++) begin
                if (reg_we[i])
                    gpr[i] <= reg_d;
            end
        end
    end

    function automatic logic [N-1:0] read_port(input logic [A-1:0] addr);
        read_port = '0;
        if (state == RUN && addr != '0) begin
            if (BYPASS != 0 && w && waddr == addr) begin
                read_port = wdata;
            end else begin
                for (int i = 1; i < NREGS; i++) begin
                    if (addr == A'(i))
                        read_port = gpr[i];
                end
            end
        end
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

    // The tap observes storage only, so a pending write shows up one cycle later.
    generate
        if (TAP_REG == 0) begin : g_tap_zero
            assign tap = '0;
        end else begin : g_tap_reg
            assign tap = (state == RUN) ? gpr[TAP_REG] : '0;
        end
    endgenerate

    assign busy = (state == INIT);

endmodule

// File: tb/tb_regs_param.sv
// Scoreboard bench for regs_param: a bypassing and a non-bypassing instance share stimulus.
module tb_regs_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       w = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr1 = '0;
    logic [2:0] raddr2 = '0;

    logic [7:0] rdata1_b, rdata2_b, tap_b;
    logic [7:0] rdata1_n, rdata2_n, tap_n;
    logic       busy_b, busy_n;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    regs_param #(.N(8), .NREGS(8), .BYPASS(1), .TAP_REG(7)) dut_b (
        .clk(clk), .reset(reset), .w(w), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_b), .rdata2(rdata2_b), .tap(tap_b), .busy(busy_b)
    );

    regs_param #(.N(8), .NREGS(8), .BYPASS(0), .TAP_REG(7)) dut_n (
        .clk(clk), .reset(reset), .w(w), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_n), .rdata2(rdata2_n), .tap(tap_n), .busy(busy_n)
    );

    function automatic string sigName(input int sig);
        case (sig)
            0: sigName = "rdata1_bypass";
            1: sigName = "rdata2_bypass";
            2: sigName = "tap_bypass";
            3: sigName = "busy_bypass";
            4: sigName = "rdata1_nobypass";
            5: sigName = "rdata2_nobypass";
            6: sigName = "tap_nobypass";
            default: sigName = "busy_nobypass";
        endcase
    endfunction

    function automatic logic [7:0] sigValue(input int sig);
        case (sig)
            0: sigValue = rdata1_b;
            1: sigValue = rdata2_b;
            2: sigValue = tap_b;
            3: sigValue = {7'd0, busy_b};
            4: sigValue = rdata1_n;
            5: sigValue = rdata2_n;
            6: sigValue = tap_n;
            default: sigValue = {7'd0, busy_n};
        endcase
    endfunction

    task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] wa,
                                 input logic [7:0] wd, input logic [2:0] a1, input logic [2:0] a2);
        @(posedge clk);
        #1;
        reset  = rst;
        w      = we;
        waddr  = wa;
        wdata  = wd;
        raddr1 = a1;
        raddr2 = a2;
    endtask

    function automatic void pushExp(input int sig, input logic [7:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.val  = v;
        e.name = name;
        sbq.push_back(e);
    endfunction

    function automatic void expectCycle(input string name, input logic [7:0] r1b, input logic [7:0] r2b,
                                        input logic [7:0] r1n, input logic [7:0] r2n,
                                        input logic [7:0] tapv, input logic busyv);
        pushExp(0, r1b, name);
        pushExp(1, r2b, name);
        pushExp(2, tapv, name);
        pushExp(3, {7'd0, busyv}, name);
        pushExp(4, r1n, name);
        pushExp(5, r2n, name);
        pushExp(6, tapv, name);
        pushExp(7, {7'd0, busyv}, name);
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [7:0] act;
        act = sigValue(e.sig);
        checks++;
        if (act === e.val) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s %s cycle=%0d actual=%h required=%h",
                     e.name, sigName(e.sig), e.cyc, act, e.val);
        end
    endtask

    // Monitor: pops every expectation recorded for the current cycle and compares it.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                $display("[TB] FAIL %s %s stale cycle=%0d actual=unsampled required=%h",
                         e.name, sigName(e.sig), e.cyc, e.val);
            end else begin
                checkOutput(e);
            end
        end
    end

    initial begin
        // Reset and full clear sequence.
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        expectCycle("reset_hold", 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, 0, 8'h00, 3'(k), 3'(7 - k));
            expectCycle("init_busy", 0, 0, 0, 0, 0, 1);
        end
        for (int a = 0; a < 8; a++) begin
            applyStimulus(0, 0, 0, 8'h00, 3'(a), 3'(a));
            expectCycle("run_zero", 0, 0, 0, 0, 0, 0);
        end

        // Write then read back.
        applyStimulus(0, 1, 3, 8'hA5, 3, 3);
        expectCycle("wr_r3_same_cycle", 8'hA5, 8'hA5, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 3, 3);
        expectCycle("rd_r3", 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 3);
        expectCycle("rd_r0_r3", 0, 8'hA5, 0, 8'hA5, 0, 0);

        // Forwarding versus stored value.
        applyStimulus(0, 1, 5, 8'h11, 0, 0);
        expectCycle("wr_r5_11", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 8'h3C, 5, 3);
        expectCycle("bypass_r5", 8'h3C, 8'hA5, 8'h11, 8'hA5, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 5, 5);
        expectCycle("rd_r5_after", 8'h3C, 8'h3C, 8'h3C, 8'h3C, 0, 0);
        applyStimulus(0, 1, 5, 8'h77, 5, 5);
        expectCycle("dual_bypass", 8'h77, 8'h77, 8'h3C, 8'h3C, 0, 0);

        // Register %0 protection.
        applyStimulus(0, 1, 0, 8'hFF, 0, 0);
        expectCycle("wr_r0_bypass", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
        expectCycle("rd_r0", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 3, 5);
        expectCycle("others_intact", 8'hA5, 8'h77, 8'hA5, 8'h77, 0, 0);

        // Tap and INIT write lockout.
        applyStimulus(0, 1, 2, 8'h55, 0, 0);
        expectCycle("wr_r2_55", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 8'h42, 7, 2);
        expectCycle("tap_not_bypassed", 8'h42, 8'h55, 0, 8'h55, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 7, 2);
        expectCycle("tap_r7", 8'h42, 8'h55, 8'h42, 8'h55, 8'h42, 0);
        applyStimulus(1, 0, 0, 8'h00, 7, 2);
        expectCycle("reset_edge_pending", 8'h42, 8'h55, 8'h42, 8'h55, 8'h42, 0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 1, 2, 8'h99, 2, 7);
            expectCycle("init_lockout", 0, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 8'h00, 2, 7);
        expectCycle("r2_after_init", 0, 0, 0, 0, 0, 0);

        // Reset during INIT restarts the clear.
        applyStimulus(0, 1, 1, 8'h12, 1, 6);
        expectCycle("wr_r1", 8'h12, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 6, 8'h34, 1, 6);
        expectCycle("wr_r6", 8'h12, 8'h34, 8'h12, 0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 1, 6);
        expectCycle("rd_r1_r6", 8'h12, 8'h34, 8'h12, 8'h34, 0, 0);
        applyStimulus(1, 0, 0, 8'h00, 1, 6);
        expectCycle("reset2_pending", 8'h12, 8'h34, 8'h12, 8'h34, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 8'h00, 1, 6);
            expectCycle("init_partial", 0, 0, 0, 0, 0, 1);
        end
        applyStimulus(1, 0, 0, 8'h00, 1, 6);
        expectCycle("mid_init_reset", 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, 0, 8'h00, 1, 6);
            expectCycle("init_restart", 0, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 8'h00, 1, 6);
        expectCycle("restart_done", 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 3, 7);
        expectCycle("all_cleared", 0, 0, 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sbq.size() > 0; k++)
            @(posedge clk);
        if (sbq.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain actual=%0d pending required=0", sbq.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
